// File: rtl/sym_ib_pkg.sv
// Shared constants for the symmetric VN information-bottleneck LUT path:
// table geometry and the loader FSM state encoding.
package sym_ib_pkg;

    localparam int VN_LUT_DATA_W = 4;
    localparam int VN_LUT_ADDR_W = 7;
    localparam int VN_LUT_DEPTH  = 128;

    localparam logic [1:0] LDR_IDLE  = 2'd0;
    localparam logic [1:0] LDR_LOAD  = 2'd1;
    localparam logic [1:0] LDR_FLUSH = 2'd2;
    localparam logic [1:0] LDR_DONE  = 2'd3;

endpackage

// File: rtl/sym_vn_lut_loader.sv
// Write-side loader for the symmetric VN LUT RAM: streams one full table of
// entries into the RAM write port and flags when the table may be read.
module sym_vn_lut_loader
    import sym_ib_pkg::*;
#(
    parameter int DATA_W = VN_LUT_DATA_W,
    parameter int ADDR_W = VN_LUT_ADDR_W,
    parameter int DEPTH  = VN_LUT_DEPTH
) (
    input  logic              write_clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [DATA_W-1:0] ib_data,
    input  logic              ib_valid,
    output logic              ib_ready,
    output logic [DATA_W-1:0] lut_in,
    output logic [ADDR_W-1:0] write_addr,
    output logic              we,
    output logic              busy,
    output logic              load_done,
    output logic              lut_ready,
    output logic [1:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] count;
    logic              accept;
    logic              last_entry;
    logic              start_ok;

    // Handshake: an entry transfers on a rising edge where ib_valid and
    // ib_ready are both 1; upstream holds ib_data/ib_valid until then, and
    // ib_ready never depends on ib_valid.
    assign ib_ready   = (state == LDR_LOAD);
    assign accept     = ib_valid & ib_ready;
    assign last_entry = (count == LAST_ADDR);
    assign start_ok   = (state == LDR_IDLE) & load_start;
    assign busy       = (state == LDR_LOAD) | (state == LDR_FLUSH);
    assign state_dbg  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            LDR_IDLE:  if (load_start) state_nxt = LDR_LOAD;
            LDR_LOAD:  if (accept && last_entry) state_nxt = LDR_FLUSH;
            LDR_FLUSH: state_nxt = LDR_DONE;
            LDR_DONE:  state_nxt = LDR_IDLE;
            default:   state_nxt = LDR_IDLE;
        endcase
    end

    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state <= LDR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The counter holds at DEPTH-1 on the final accept instead of wrapping.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start_ok) begin
            count <= '0;
        end else if (accept && !last_entry) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            we         <= 1'b0;
            lut_in     <= '0;
            write_addr <= '0;
        end else begin
            we <= accept;
            if (accept) begin
                lut_in     <= ib_data;
                write_addr <= count;
            end
        end
    end

    // lut_ready rises only after the final write has landed in the RAM, so it
    // is never 1 while we can be 1.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            load_done <= 1'b0;
            lut_ready <= 1'b0;
        end else begin
            load_done <= (state == LDR_DONE);
            if (start_ok) begin
                lut_ready <= 1'b0;
            end else if (state == LDR_DONE) begin
                lut_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench for sym_vn_lut_loader: directed table loads with a
// write scoreboard, a behavioural RAM for readback, and FSM boundary checks.
module tb_sym_vn_lut_loader;
    import sym_ib_pkg::*;

    localparam int DW    = 4;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          write_clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [DW-1:0] ib_data;
    logic          ib_valid;
    logic          ib_ready;
    logic [DW-1:0] lut_in;
    logic [AW-1:0] write_addr;
    logic          we;
    logic          busy;
    logic          load_done;
    logic          lut_ready;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int ld_cnt   = 0;
    int done_cyc = 0;
    int ecount   = 0;
    int ls_edge  = 0;

    // Expected write: {lut_ready, write_addr, lut_in}
    logic [DW+AW:0] exp_q[$];
    logic [DW-1:0]  ram [DEPTH];

    sym_vn_lut_loader dut (
        .write_clk  (write_clk),
        .rst        (rst),
        .load_start (load_start),
        .ib_data    (ib_data),
        .ib_valid   (ib_valid),
        .ib_ready   (ib_ready),
        .lut_in     (lut_in),
        .write_addr (write_addr),
        .we         (we),
        .busy       (busy),
        .load_done  (load_done),
        .lut_ready  (lut_ready),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    always #5 write_clk = ~write_clk;

    always @(posedge write_clk) begin
        ecount <= ecount + 1;
        if (we) ram[write_addr] <= lut_in;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat_val(input int pat, input int idx);
        logic [DW-1:0] v;
        v = DW'(idx % 16);
        if (pat == 1) v = 4'd15 - v;
        return v;
    endfunction

    // Scoreboard monitor
    always @(negedge write_clk) begin
        if (!rst) begin
            if (we) begin
                wr_cnt++;
                if (exp_q.size() == 0) chk("unexpected_write", int'(write_addr), -1);
                else chk("write", int'({lut_ready, write_addr, lut_in}), int'(exp_q.pop_front()));
            end
            if (load_done) begin
                ld_cnt++;
                done_cyc = ecount;
            end
        end
    end

    // Driver tasks
    task automatic start_load();
        @(negedge write_clk);
        load_start = 1'b1;
        ls_edge = ecount;
        @(negedge write_clk);
        load_start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic stream(input int pat, input int stall_every, input int ls_a,
                          input int ls_b, input int stop_at);
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        logic prev_acc = 1'b0;
        while (idx < stop_at) begin
            if (cyc >= 4 * DEPTH) begin
                chk("stream_timeout", idx, stop_at);
                break;
            end
            chk("we_align", we, prev_acc);
            chk("lut_ready_low", lut_ready, 0);
            ib_valid   = !(stall_every != 0 && (cyc % stall_every) == stall_every - 1);
            ib_data    = pat_val(pat, idx);
            load_start = (idx == ls_a) || (idx == ls_b);
            acc = ib_valid && ib_ready;
            if (acc) begin
                exp_q.push_back({1'b0, AW'(idx), ib_data});
                idx++;
            end
            prev_acc = acc;
            cyc++;
            @(negedge write_clk);
        end
        ib_valid   = 1'b0;
        load_start = 1'b0;
    endtask

    // Called at the negedge of the FLUSH cycle.
    task automatic finish_load(input bit ls_in_done, input int wr_before, input int ld_before);
        chk("flush_state", state_dbg, int'(LDR_FLUSH));
        chk("flush_busy", busy, 1);
        chk("flush_ready", ib_ready, 0);
        @(negedge write_clk);
        chk("done_state", state_dbg, int'(LDR_DONE));
        chk("done_busy", busy, 0);
        chk("done_lut_ready", lut_ready, 0);
        chk("done_we", we, 0);
        if (ls_in_done) load_start = 1'b1;
        @(negedge write_clk);
        load_start = 1'b0;
        chk("load_done", load_done, 1);
        chk("lut_ready_set", lut_ready, 1);
        chk("idle_state", state_dbg, int'(LDR_IDLE));
        @(negedge write_clk);
        chk("load_done_pulse", load_done, 0);
        chk("lut_ready_hold", lut_ready, 1);
        chk("stay_idle", busy, 0);
        chk("write_count", wr_cnt - wr_before, DEPTH);
        chk("done_count", ld_cnt - ld_before, 1);
    endtask

    task automatic readback(input int pat);
        for (int i = 0; i < DEPTH; i++) chk("readback", ram[i], pat_val(pat, i));
    endtask

    task automatic full_load(input int pat, input int stall_every, input int ls_a,
                             input int ls_b, input bit ls_in_done);
        int wr0;
        int ld0;
        wr0 = wr_cnt;
        ld0 = ld_cnt;
        start_load();
        stream(pat, stall_every, ls_a, ls_b, DEPTH);
        finish_load(ls_in_done, wr0, ld0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        ib_valid   = 1'b0;
        ib_data    = '0;
        repeat (3) @(negedge write_clk);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", int'({ib_ready, load_done, lut_ready, lut_in, write_addr}), 0);
        chk("rst_state", state_dbg, int'(LDR_IDLE));
        rst = 1'b0;
        @(negedge write_clk);
        chk("post_rst_idle", int'({busy, ib_ready, lut_ready}), 0);

        // 1: uninterrupted load, latency from load_start to load_done
        full_load(0, 0, -1, -1, 1'b0);
        chk("latency", done_cyc - ls_edge, 131);
        readback(0);

        // 2: ib_valid dropped every 3rd cycle
        full_load(1, 3, -1, -1, 1'b0);
        readback(1);

        // 3: load_start while busy and in DONE is ignored
        full_load(0, 0, 10, 127, 1'b1);
        readback(0);

        // 4: reset after entry 50, then a clean reload
        start_load();
        stream(1, 0, -1, -1, 51);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_lut_ready", lut_ready, 0);
        chk("abort_state", state_dbg, int'(LDR_IDLE));
        chk("abort_queue", exp_q.size(), 0);
        exp_q.delete();
        @(negedge write_clk);
        rst = 1'b0;
        full_load(1, 0, -1, -1, 1'b0);
        readback(1);

        // 6: ib_valid in IDLE is not accepted
        for (int i = 0; i < 8; i++) begin
            @(negedge write_clk);
            ib_valid = 1'b1;
            ib_data  = DW'(i);
            chk("idle_ready", ib_ready, 0);
            chk("idle_we", we, 0);
        end
        ib_valid = 1'b0;

        // 5: reload over a valid table with the inverted pattern
        full_load(1, 0, -1, -1, 1'b0);
        readback(1);
        full_load(0, 2, -1, -1, 1'b0);
        readback(0);

        repeat (2) @(negedge write_clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
